// File: rtl/chk_checkerboard.sv
// ============================================================================
// Module   : chk_checkerboard
// Purpose  : Issues LENGTH in-order read requests and checks the returned
//            words against the checkerboard pattern. It reports the error
//            count, completion and pass/fail.
// Options  : CHK_FIRST_ERR_EN - when defined, captures the index and data of
//            the first mismatching word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chk_checkerboard #(
  parameter int WIDTH           = 8,
  parameter int LENGTH          = 16,
  parameter int INVERT_VALUES   = 0,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CW = $clog2(LENGTH + 1),
  localparam int IW = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             enbl_i,
  output logic             rd_req_o,
  input  logic [WIDTH-1:0] rd_data_i,
  input  logic             rd_valid_i,
  output logic             finished_o,
  output logic             pass_o,
  output logic [CW-1:0]    err_cnt_o,
  output logic [IW-1:0]    first_err_idx_o,
  output logic [WIDTH-1:0] first_err_data_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] even_pattern();
    logic [WIDTH-1:0] p;
    for (int i = 0; i < WIDTH; i++) begin
      p[i] = ((i % 2) == 0) != (INVERT_VALUES != 0);
    end
    return p;
  endfunction

  localparam logic [WIDTH-1:0] PAT_EVEN = even_pattern();

  state_t          state;
  logic [CW-1:0]   req_cnt;
  logic [CW-1:0]   rsp_cnt;
  logic [CW-1:0]   err_cnt;
  logic            rd_req;
  logic            finished;
  logic            pass;

  logic            active;
  logic [CW-1:0]   req_next;
  logic [CW-1:0]   rsp_next;
  logic [CW-1:0]   err_next;
  logic [CW-1:0]   out_next;
  logic            accept;
  logic            mismatch;
  logic            last_rsp;
  logic            can_issue;
  logic [WIDTH-1:0] expected;

  // The request visible this cycle already counts as outstanding, so a
  // zero-latency response to it is accepted rather than treated as spurious.
  always_comb begin
    active    = (state == RUN) || (state == DRAIN);
    req_next  = req_cnt + CW'(rd_req);
    accept    = rd_valid_i && active && (req_next != rsp_cnt);
    rsp_next  = rsp_cnt + CW'(accept);
    expected  = rsp_cnt[0] ? ~PAT_EVEN : PAT_EVEN;
    mismatch  = accept && (rd_data_i != expected);
    err_next  = err_cnt + CW'(mismatch);
    out_next  = req_next - rsp_next;
    last_rsp  = accept && (int'(rsp_cnt) == LENGTH - 1);
    can_issue = enbl_i && (int'(req_next) < LENGTH) &&
                (int'(out_next) < MAX_OUTSTANDING);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state    <= IDLE;
      req_cnt  <= '0;
      rsp_cnt  <= '0;
      err_cnt  <= '0;
      rd_req   <= 1'b0;
      finished <= 1'b0;
      pass     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enbl_i) state <= RUN;
        end
        RUN, DRAIN: begin
          req_cnt <= req_next;
          rsp_cnt <= rsp_next;
          err_cnt <= err_next;
          rd_req  <= (state == RUN) && can_issue;
          if (last_rsp) begin
            state    <= DONE;
            rd_req   <= 1'b0;
            finished <= 1'b1;
            pass     <= (err_next == '0);
          end else if ((state == RUN) && (int'(req_next) == LENGTH)) begin
            state <= DRAIN;
          end
        end
        default: begin
          rd_req <= 1'b0;
        end
      endcase
    end
  end

  assign rd_req_o   = rd_req;
  assign finished_o = finished;
  assign pass_o     = pass;
  assign err_cnt_o  = err_cnt;

`ifdef CHK_FIRST_ERR_EN
  logic             have_err;
  logic [IW-1:0]    err_idx;
  logic [WIDTH-1:0] err_data;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      have_err <= 1'b0;
      err_idx  <= '0;
      err_data <= '0;
    end else if (mismatch && !have_err) begin
      have_err <= 1'b1;
      err_idx  <= rsp_cnt[IW-1:0];
      err_data <= rd_data_i;
    end
  end

  assign first_err_idx_o  = err_idx;
  assign first_err_data_o = err_data;
`else
  assign first_err_idx_o  = '0;
  assign first_err_data_o = '0;
`endif

endmodule

`default_nettype wire

// File: doc/chk_checkerboard.md
Name: chk_checkerboard

Overview:
Read-side counterpart to the checkerboard write generator. It issues LENGTH read requests and receives the read data in order. Each returned word is compared against the same checkerboard pattern the generator wrote. Mismatches are counted, and the block reports completion and pass/fail, closing the write-then-verify loop of the eMMC memory test.

Parameters:
WIDTH, 8, data word width in bits (>= 2)
LENGTH, 16, number of words to read and check (>= 1)
INVERT_VALUES, 0, 1 = expect the inverted checkerboard (must match the generator's setting)
MAX_OUTSTANDING, 4, maximum issued-but-unanswered requests (>= 1)

Ports:
clk_i  in  1  clock
srst_i  in  1  synchronous active-high reset
enbl_i  in  1  run enable; low pauses request issue
rd_req_o  out  1  read request; one word per high cycle; sink always accepts
rd_data_i  in  WIDTH  returned read data
rd_valid_i  in  1  rd_data_i valid this cycle; responses are in request order, any latency
finished_o  out  1  all LENGTH responses checked; sticky until srst_i
pass_o  out  1  finished_o && err_cnt_o == 0
err_cnt_o  out  $clog2(LENGTH+1)  number of mismatching words
first_err_idx_o  out  $clog2(LENGTH)  word index of the first mismatch (feature-gated)
first_err_data_o  out  WIDTH  data of the first mismatch (feature-gated)

Behaviour:
- Expected bit i of word k = ~i[0] ^ k[0] ^ INVERT_VALUES.
  - WIDTH=8, INVERT_VALUES=0: word0 = 0x55, word1 = 0xAA, alternating.
- srst_i dominates every other input.
  - All outputs go to 0; counters clear; state returns to IDLE.
  - A reset mid-run abandons the run. Responses arriving after reset, while in IDLE, are ignored.
- Counters:
  - req_cnt: requests issued, 0..LENGTH.
  - rsp_cnt: responses checked, 0..LENGTH.
  - outstanding = req_cnt - rsp_cnt.
- States:
  - IDLE -> RUN: on the first cycle with enbl_i=1 after reset.
  - RUN: rd_req_o (registered) is set for the next cycle iff all of:
    - enbl_i=1
    - req_cnt_next < LENGTH
    - outstanding_next < MAX_OUTSTANDING
    Here the "_next" values include the request and response of the current cycle.
  - RUN -> DRAIN: when req_cnt reaches LENGTH.
  - DRAIN: no requests; keep accepting responses.
  - DRAIN -> DONE: when rsp_cnt reaches LENGTH.
  - DONE: finished_o=1; rd_req_o=0; terminal until srst_i.
- enbl_i low in RUN:
  - Stops new requests from the next cycle on.
  - Responses are still accepted and checked.
  - Resumes with no lost or duplicated index.
- Compare timing:
  - rd_valid_i sampled in cycle t; err_cnt_o updated in cycle t+1.
  - Word index = rsp_cnt at time t.
- Request and response in the same cycle: outstanding is unchanged.
- Spurious response (rd_valid_i=1 with outstanding=0, or in IDLE/DONE): ignored; not counted, not compared.
- finished_o asserts in the same cycle that err_cnt_o reflects the final word. pass_o is valid from then on.
- err_cnt_o cannot exceed LENGTH, so no saturation logic is needed.
- Minimum run time with zero-latency responses and enbl_i held high: LENGTH + 2 cycles from IDLE exit to finished_o.

Optional Feature:
Macro CHK_FIRST_ERR_EN.
- Defined: on the first mismatch after reset, capture the word index into first_err_idx_o and the data into first_err_data_o. Both hold until srst_i; later mismatches do not overwrite them.
- Undefined: no capture registers; first_err_idx_o and first_err_data_o are tied to 0. All other behaviour is identical.

Test Plan:
- WIDTH=8, LENGTH=16, responder returns the correct pattern with 1-cycle latency, enbl_i=1:
  - 16 requests issued, data 0x55/0xAA alternating.
  - finished_o=1, err_cnt_o=0, pass_o=1.
- Same setup, responder corrupts word 5 (returns 0x55 instead of 0xAA) and word 9 (0x00):
  - err_cnt_o=2, pass_o=0.
  - With CHK_FIRST_ERR_EN: first_err_idx_o=5, first_err_data_o=0x55.
- Responder latency 10 cycles, MAX_OUTSTANDING=4:
  - Never more than 4 outstanding requests.
  - rd_req_o stalls while 4 are outstanding.
  - Run completes with err_cnt_o=0.
- enbl_i dropped for 6 cycles after the 7th request:
  - No requests during the pause.
  - Pending responses are checked.
  - Resumes at index 7; exactly 16 requests total; pass_o=1.
- srst_i pulsed mid-run at rsp_cnt=8, then restarted:
  - All outputs are 0 in the cycle after reset.
  - Stale responses in IDLE are ignored.
  - The new run checks from word 0; pass_o=1.
- INVERT_VALUES=1 with an inverted responder:
  - Expects 0xAA at word 0 and passes.
  - Feeding a non-inverted responder gives err_cnt_o=16.
